top_fdct_mac_pipe: RTL and testbench

Parametrised, pipelined signed multiply-accumulate unit for the FDCT datapath. It is the successor to the fixed-width single-cycle combinational multipliers. It adds:
- configurable operand, accumulator and output widths;
- configurable pipeline depth;
- per-beat accumulate control;
- round-half-up descaling with saturation;
- a valid/ready handshake with full backpressure.

It sits between the coefficient/sample fetch logic and the row/column transpose buffer.

---
 rtl/top_fdct_mac_pkg.sv | 43 ++++
 rtl/top_fdct_mac_descale.sv | 28 ++
 rtl/top_fdct_mac_pipe.sv | 154 +++++++++++++++
 tb/tb_top_fdct_mac_pipe.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/top_fdct_mac_pkg.sv
// Shared types and helpers for the FDCT multiply-accumulate pipeline.
// Saturation works on a wide signed carrier so one helper serves every width.
package top_fdct_mac_pkg;

    localparam int SAT_WIDTH = 128;

    typedef logic signed [SAT_WIDTH-1:0] wide_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } beat_ctl_t;

    function automatic int prod_width(input int a_width, input int b_width);
        return a_width + b_width;
    endfunction

    // Half an LSB of the descaled result, added before the arithmetic shift.
    function automatic wide_t round_const(input int shift);
        wide_t one;
        one = wide_t'(1);
        if (shift > 0) begin
            return one <<< (shift - 1);
        end
        return '0;
    endfunction

    function automatic wide_t sat(input wide_t value, input int width);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/top_fdct_mac_descale.sv
// Round-half-up descale of the accumulator followed by saturation to the
// output width; purely combinational.
module top_fdct_mac_descale
    import top_fdct_mac_pkg::*;
#(
    parameter int ACC_WIDTH = 36,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 13
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    output logic signed [OUT_WIDTH-1:0] value,
    output logic                        ovf
);

    localparam logic signed [ACC_WIDTH:0] ROUND = (ACC_WIDTH + 1)'(round_const(SHIFT));

    logic signed [ACC_WIDTH:0] shifted;
    wide_t                     clamped;

    // One extra bit keeps the rounding add from wrapping near the positive limit.
    always_comb begin
        shifted = ((ACC_WIDTH + 1)'(acc) + ROUND) >>> SHIFT;
        clamped = sat(wide_t'(shifted), OUT_WIDTH);
        value   = clamped[OUT_WIDTH-1:0];
        ovf     = (clamped != wide_t'(shifted));
    end

endmodule

// File: rtl/top_fdct_mac_pipe.sv
// Pipelined signed multiply-accumulate with descale, saturation and a
// valid/ready handshake; a stalled output freezes the whole pipeline.
module top_fdct_mac_pipe
    import top_fdct_mac_pkg::*;
#(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 15,
    parameter int ACC_WIDTH = 36,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 13,
    parameter int NUM_STAGE = 3,
    parameter bit ACC_EN    = 1'b1
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [A_WIDTH-1:0]   in_a,
    input  logic signed [B_WIDTH-1:0]   in_b,
    input  logic                        in_first,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        out_ovf
);

    localparam int PROD_WIDTH = prod_width(A_WIDTH, B_WIDTH);
    localparam int PIPE_DEPTH = NUM_STAGE - 2;

    if (NUM_STAGE < 2) begin : g_bad_num_stage
        $error("NUM_STAGE must be at least 2");
    end
    if (ACC_WIDTH < PROD_WIDTH) begin : g_bad_acc_width
        $error("ACC_WIDTH must hold the full product");
    end
    if (OUT_WIDTH > ACC_WIDTH) begin : g_bad_out_width
        $error("OUT_WIDTH must not exceed ACC_WIDTH");
    end

    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = ap_rst_n && !stall;

    beat_ctl_t                    s1_ctl;
    logic signed [A_WIDTH-1:0]    s1_a;
    logic signed [B_WIDTH-1:0]    s1_b;
    logic signed [PROD_WIDTH-1:0] s1_prod;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            s1_ctl <= '0;
        end else if (!stall) begin
            s1_ctl.valid <= in_valid;
            s1_ctl.first <= ACC_EN ? in_first : 1'b1;
            s1_ctl.last  <= ACC_EN ? in_last  : 1'b1;
        end
    end

    // NOTE: operand/product registers are not reset; the valid flags travelling with them decide whether they are ever used.
    always_ff @(posedge ap_clk) begin
        if (!stall) begin
            s1_a <= in_a;
            s1_b <= in_b;
        end
    end

    assign s1_prod = PROD_WIDTH'(s1_a) * PROD_WIDTH'(s1_b);

    beat_ctl_t                    fin_ctl;
    logic signed [PROD_WIDTH-1:0] fin_prod;

    if (PIPE_DEPTH == 0) begin : g_comb_prod
        assign fin_ctl  = s1_ctl;
        assign fin_prod = s1_prod;
    end else begin : g_prod_pipe
        beat_ctl_t                    ctl_q  [PIPE_DEPTH];
        logic signed [PROD_WIDTH-1:0] prod_q [PIPE_DEPTH];

        always_ff @(posedge ap_clk) begin
            if (!ap_rst_n) begin
                for (int i = 0; i < PIPE_DEPTH; i++) ctl_q[i] <= '0;
            end else if (!stall) begin
                ctl_q[0] <= s1_ctl;
                for (int i = 1; i < PIPE_DEPTH; i++) ctl_q[i] <= ctl_q[i-1];
            end
        end

        always_ff @(posedge ap_clk) begin
            if (!stall) begin
                prod_q[0] <= s1_prod;
                for (int i = 1; i < PIPE_DEPTH; i++) prod_q[i] <= prod_q[i-1];
            end
        end

        assign fin_ctl  = ctl_q[PIPE_DEPTH-1];
        assign fin_prod = prod_q[PIPE_DEPTH-1];
    end

    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_base;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [ACC_WIDTH:0]   sum;
    logic                        ovf_q;
    logic                        ovf_next;
    logic                        acc_sat;
    logic signed [OUT_WIDTH-1:0] ds_value;
    logic                        ds_ovf;

    // Overflow of the signed add shows as disagreement of the two top sum bits.
    always_comb begin
        acc_base = fin_ctl.first ? '0 : acc_q;
        sum      = (ACC_WIDTH + 1)'(acc_base) + (ACC_WIDTH + 1)'(fin_prod);
        acc_sat  = (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]);
        acc_next = acc_sat ? {sum[ACC_WIDTH], {(ACC_WIDTH-1){~sum[ACC_WIDTH]}}}
                           : sum[ACC_WIDTH-1:0];
        ovf_next = (fin_ctl.first ? 1'b0 : ovf_q) | acc_sat;
    end

    top_fdct_mac_descale #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_descale (
        .acc   (acc_next),
        .value (ds_value),
        .ovf   (ds_ovf)
    );

    // Clearing after a last beat makes a following beat behave as a first.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (!stall) begin
            out_valid <= fin_ctl.valid && fin_ctl.last;
            if (fin_ctl.valid) begin
                if (fin_ctl.last) begin
                    acc_q    <= '0;
                    ovf_q    <= 1'b0;
                    out_data <= ds_value;
                    out_ovf  <= ovf_next | ds_ovf;
                end else begin
                    acc_q <= acc_next;
                    ovf_q <= ovf_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_top_fdct_mac_pipe.sv
// Bench for top_fdct_mac_pipe: an accumulating and a multiply-only instance
// share stimulus and are each checked against an arithmetic reference model.
module tb_top_fdct_mac_pipe;

    localparam int A_W   = 16;
    localparam int B_W   = 15;
    localparam int ACC_W = 36;
    localparam int OUT_W = 16;
    localparam int SH    = 13;
    localparam int NS    = 3;

    localparam longint ACC_MAX = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint ACC_MIN = -ACC_MAX - 1;
    localparam longint OUT_MAX = (longint'(1) <<< (OUT_W - 1)) - 1;
    localparam longint OUT_MIN = -OUT_MAX - 1;
    localparam longint ROUND   = (SH > 0) ? (longint'(1) <<< (SH - 1)) : 0;

    localparam logic signed [A_W-1:0] A_MAX = {1'b0, {(A_W-1){1'b1}}};
    localparam logic signed [A_W-1:0] A_MIN = {1'b1, {(A_W-1){1'b0}}};
    localparam logic signed [B_W-1:0] B_MAX = {1'b0, {(B_W-1){1'b1}}};
    localparam logic signed [B_W-1:0] B_MIN = {1'b1, {(B_W-1){1'b0}}};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_n;
    logic                    in_valid;
    logic                    in_first;
    logic                    in_last;
    logic                    out_ready;
    logic signed [A_W-1:0]   in_a;
    logic signed [B_W-1:0]   in_b;
    logic                    iry0, iry1, ov0, ov1, oo0, oo1;
    logic signed [OUT_W-1:0] od0, od1;

    top_fdct_mac_pipe #(
        .A_WIDTH(A_W), .B_WIDTH(B_W), .ACC_WIDTH(ACC_W), .OUT_WIDTH(OUT_W),
        .SHIFT(SH), .NUM_STAGE(NS), .ACC_EN(1'b1)
    ) u_dut_acc (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(iry0),
        .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_ovf(oo0)
    );

    top_fdct_mac_pipe #(
        .A_WIDTH(A_W), .B_WIDTH(B_W), .ACC_WIDTH(ACC_W), .OUT_WIDTH(OUT_W),
        .SHIFT(SH), .NUM_STAGE(NS), .ACC_EN(1'b0)
    ) u_dut_mul (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(iry1),
        .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_ovf(oo1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted beat is folded in with plain integer math.
    typedef struct {
        longint data;
        bit     ovf;
    } res_t;

    res_t   expq0[$];
    res_t   expq1[$];
    longint acc_m [2];
    bit     ovf_m [2];
    bit     rst_edge = 1'b0;
    bit     chk_en   = 1'b0;
    bit     collect  = 1'b0;
    bit     saw_stall = 1'b0;
    longint col_q[$];

    task automatic model_beat(input int d, input longint a, input longint b,
                              input bit first, input bit last);
        longint s;
        longint r;
        bit     o;
        res_t   e;
        if (d == 1) begin
            first = 1'b1;
            last  = 1'b1;
        end
        s = (first ? 64'sd0 : acc_m[d]) + a * b;
        o = first ? 1'b0 : ovf_m[d];
        if (s > ACC_MAX) begin s = ACC_MAX; o = 1'b1; end
        if (s < ACC_MIN) begin s = ACC_MIN; o = 1'b1; end
        if (last) begin
            r = (s + ROUND) >>> SH;
            if (r > OUT_MAX) begin r = OUT_MAX; o = 1'b1; end
            if (r < OUT_MIN) begin r = OUT_MIN; o = 1'b1; end
            e.data = r;
            e.ovf  = o;
            if (d == 0) expq0.push_back(e);
            else        expq1.push_back(e);
            acc_m[d] = 0;
            ovf_m[d] = 1'b0;
        end else begin
            acc_m[d] = s;
            ovf_m[d] = o;
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            expq0.delete();
            expq1.delete();
            acc_m    = '{0, 0};
            ovf_m    = '{1'b0, 1'b0};
            rst_edge = 1'b1;
        end else begin
            rst_edge = 1'b0;
            if (ov0 && out_ready && expq0.size() > 0) void'(expq0.pop_front());
            if (ov1 && out_ready && expq1.size() > 0) void'(expq1.pop_front());
            if (collect && ov1 && out_ready) col_q.push_back(longint'(od1));
            if (collect && in_valid && !iry0) saw_stall = 1'b1;
            if (in_valid && iry0) model_beat(0, in_a, in_b, in_first, in_last);
            if (in_valid && iry1) model_beat(1, in_a, in_b, in_first, in_last);
        end
    end

    task automatic compare_dut(input int d);
        logic                    v, r, o;
        logic signed [OUT_W-1:0] data;
        int                      qs;
        res_t                    e;
        e.data = 0;
        e.ovf  = 1'b0;
        if (d == 0) begin
            v = ov0; r = iry0; o = oo0; data = od0; qs = expq0.size();
            if (qs > 0) e = expq0[0];
        end else begin
            v = ov1; r = iry1; o = oo1; data = od1; qs = expq1.size();
            if (qs > 0) e = expq1[0];
        end
        if (!rst_n) check($sformatf("dut%0d_ready_in_reset", d), r, 0);
        else        check($sformatf("dut%0d_ready_vs_stall", d), r, !(v && !out_ready));
        if (rst_edge) begin
            check($sformatf("dut%0d_valid_after_reset", d), v, 0);
            check($sformatf("dut%0d_data_after_reset", d), data, 0);
            check($sformatf("dut%0d_ovf_after_reset", d), o, 0);
        end else if (qs == 0) begin
            check($sformatf("dut%0d_valid_without_result", d), v, 0);
        end else if (v) begin
            check($sformatf("dut%0d_data", d), data, e.data);
            check($sformatf("dut%0d_ovf", d), o, e.ovf);
        end
    endtask

    always @(negedge clk) begin
        #1;
        if (chk_en) begin
            compare_dut(0);
            compare_dut(1);
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input longint a, input longint b, input bit first, input bit last);
        int n = 0;
        in_valid = 1'b1;
        in_a     = A_W'(a);
        in_b     = B_W'(b);
        in_first = first;
        in_last  = last;
        @(posedge clk);
        while (!iry0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", n, 0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input longint exp_d, input bit exp_o);
        int n = 0;
        while (!ov0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_seen"}, ov0, 1);
        check({name, "_data"}, od0, exp_d);
        check({name, "_ovf"}, oo0, exp_o);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", ov0, 0);
        check("reset_out_data", od0, 0);
        check("reset_in_ready", iry0, 0);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        @(negedge clk);

        // Multiply-only instance ignores first/last and answers after NS-1 edges.
        in_valid = 1'b1; in_a = 1000; in_b = 8192; in_first = 1'b0; in_last = 1'b0;
        @(posedge clk);
        check("mul_accepted", iry1, 1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!ov1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mul_latency", n, NS - 1);
        check("mul_data", od1, 1000);
        check("mul_ovf", oo1, 0);
        @(negedge clk);

        send(3, 4096, 1, 1);       expect_out("round_p3", 2, 0);
        send(-3, 4096, 1, 1);      expect_out("round_m3", -1, 0);
        send(1, 4096, 1, 1);       expect_out("round_p1", 1, 0);
        send(-1, 4096, 1, 1);      expect_out("round_m1", 0, 0);
        send(32767, 16383, 1, 1);  expect_out("sat_pos", 32767, 1);
        send(-32768, 16383, 1, 1); expect_out("sat_neg", -32768, 1);

        for (int i = 0; i < 8; i++) send(100, 8192, i == 0, i == 7);
        expect_out("acc_group_pos", 800, 0);
        for (int i = 0; i < 8; i++) send(-50, 8192, i == 0, i == 7);
        expect_out("acc_group_neg", -400, 0);

        // Backpressure while streaming single-beat products.
        col_q.delete();
        collect   = 1'b1;
        out_ready = 1'b0;
        fork
            begin
                repeat (5) @(negedge clk);
                out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 10; i++) send(i + 1, 8192, 1, 1);
            end
        join
        n = 0;
        while (col_q.size() < 10 && n < 60) begin
            @(negedge clk);
            n++;
        end
        collect = 1'b0;
        check("bp_count", col_q.size(), 10);
        check("bp_stall_seen", saw_stall, 1);
        for (int i = 0; i < col_q.size(); i++) check($sformatf("bp_data_%0d", i), col_q[i], i + 1);

        // Reset halfway through a group; only the fresh group may produce output.
        for (int i = 0; i < 4; i++) send(100, 8192, i == 0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_valid_acc", ov0, 0);
        check("rst_mid_valid_mul", ov1, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) send(100, 8192, i == 0, i == 1);
        expect_out("rst_group", 200, 0);

        // Random traffic with bubbles and random backpressure.
        for (int c = 0; c < 2000; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_a     = A_W'($urandom);
            in_b     = B_W'($urandom);
            if ($urandom_range(0, 7) == 0) in_a = $urandom_range(0, 1) ? A_MAX : A_MIN;
            if ($urandom_range(0, 7) == 0) in_b = $urandom_range(0, 1) ? B_MAX : B_MIN;
            in_first  = ($urandom_range(0, 3) == 0);
            in_last   = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end

        // Long same-sign runs of extreme products to drive the accumulator into saturation.
        for (int c = 0; c < 1200; c++) begin
            in_valid = ($urandom_range(0, 7) != 0);
            in_a     = $urandom_range(0, 1) ? A_MAX : A_MIN;
            if (c < 600) in_b = in_a[A_W-1] ? B_MIN : B_MAX;
            else         in_b = in_a[A_W-1] ? B_MAX : B_MIN;
            in_first  = ($urandom_range(0, 149) == 0);
            in_last   = ($urandom_range(0, 119) == 0);
            out_ready = ($urandom_range(0, 7) != 0);
            @(negedge clk);
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((expq0.size() > 0 || expq1.size() > 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_acc", expq0.size(), 0);
        check("drain_mul", expq1.size(), 0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
